// File: rtl/i2c_arb_pkg.sv
// ---------------------------------------------------------------------------
// i2c_arb_pkg
// Shared definitions for the I2C request arbiter: FSM state encoding,
// command field widths and the default abort timeout used when the design
// is built with I2C_ARB_TIMEOUT_EN defined.
// ---------------------------------------------------------------------------
package i2c_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } arb_state_e;

   localparam int ADDR_W          = 16;
   localparam int DATA_W          = 8;
   localparam int CNT_W           = 16;
   localparam int TIMEOUT_CYC_DEF = 20000;

endpackage

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Starting at ptr_i and wrapping from
// NUM_REQ-1 back to 0, selects the first asserted request bit.
// Ports:
//   req_i    in   NUM_REQ   request vector
//   ptr_i    in   IDX_W     index that has highest priority this round
//   grant_o  out  NUM_REQ   one-hot selected request (all zero if none)
//   idx_o    out  IDX_W     index of the selected request
//   any_o    out  1         at least one request is asserted
// ---------------------------------------------------------------------------
module rr_pick #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = 1
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   ptr_i,
   output logic [NUM_REQ-1:0] grant_o,
   output logic [IDX_W-1:0]   idx_o,
   output logic               any_o
);

   int k;

   // Walk the requesters in priority order; the any_o flag freezes the
   // result once the first valid request has been found.
   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      any_o   = 1'b0;
      k       = 0;
      for (int off = 0; off < NUM_REQ; off++) begin
         k = (int'(ptr_i) + off) % NUM_REQ;
         if (!any_o && req_i[k]) begin
            any_o      = 1'b1;
            grant_o[k] = 1'b1;
            idx_o      = IDX_W'(k);
         end
      end
   end

endmodule

// File: rtl/i2c_req_arbiter.sv
// ---------------------------------------------------------------------------
// i2c_req_arbiter
// Shares one i2c_dri instance between NUM_REQ requesters. Round-robin
// arbitration picks a requester, latches its command, pulses i2c_exec_o,
// waits for i2c_done_i and routes done/ack/read data back to the owner.
// Clocked by i2c_dri's dri_clk.
//
// Optional build macro: I2C_ARB_TIMEOUT_EN
//   defined   : WAIT aborts after TIMEOUT_CYC cycles without i2c_done_i,
//               answering with rsp_ack_o=1, rsp_data_r_o=0 and a pulse on
//               the extra port rsp_timeout_o.
//   undefined : WAIT waits indefinitely; no rsp_timeout_o port.
//
// Ports:
//   clk_i           in   1            dri_clk
//   rst_i           in   1            synchronous active-high reset
//   req_valid_i     in   NUM_REQ      requester k holds high until accepted
//   req_rh_wl_i     in   NUM_REQ      1=read, 0=write
//   req_bit_ctrl_i  in   NUM_REQ      word address width 1=16b, 0=8b
//   req_addr_i      in   16*NUM_REQ   word address, slice k=[16k+15:16k]
//   req_data_w_i    in   8*NUM_REQ    write data, slice k=[8k+7:8k]
//   req_accept_o    out  NUM_REQ      one-hot pulse: command of k captured
//   rsp_done_o      out  NUM_REQ      one-hot pulse: transfer of k finished
//   rsp_ack_o       out  1            0=acked, 1=NACK/abort (with rsp_done)
//   rsp_data_r_o    out  8            read data, held until next rsp_done
//   rsp_timeout_o   out  1            abort pulse (timeout build only)
//   busy_o          out  1            high in ISSUE/WAIT
//   i2c_exec_o      out  1            1-cycle start pulse to i2c_dri
//   i2c_rh_wl_o     out  1            latched command fields to i2c_dri
//   bit_ctrl_o      out  1
//   i2c_addr_o      out  16
//   i2c_data_w_o    out  8
//   i2c_done_i      in   1            from i2c_dri
//   i2c_ack_i       in   1            from i2c_dri
//   i2c_data_r_i    in   8            from i2c_dri
// ---------------------------------------------------------------------------
module i2c_req_arbiter
   import i2c_arb_pkg::*;
#(
   parameter int NUM_REQ = 2
`ifdef I2C_ARB_TIMEOUT_EN
   , parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
`endif
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [NUM_REQ-1:0]        req_valid_i,
   input  logic [NUM_REQ-1:0]        req_rh_wl_i,
   input  logic [NUM_REQ-1:0]        req_bit_ctrl_i,
   input  logic [ADDR_W*NUM_REQ-1:0] req_addr_i,
   input  logic [DATA_W*NUM_REQ-1:0] req_data_w_i,
   output logic [NUM_REQ-1:0]        req_accept_o,
   output logic [NUM_REQ-1:0]        rsp_done_o,
   output logic                      rsp_ack_o,
   output logic [DATA_W-1:0]         rsp_data_r_o,
`ifdef I2C_ARB_TIMEOUT_EN
   output logic                      rsp_timeout_o,
`endif
   output logic                      busy_o,
   output logic                      i2c_exec_o,
   output logic                      i2c_rh_wl_o,
   output logic                      bit_ctrl_o,
   output logic [ADDR_W-1:0]         i2c_addr_o,
   output logic [DATA_W-1:0]         i2c_data_w_o,
   input  logic                      i2c_done_i,
   input  logic                      i2c_ack_i,
   input  logic [DATA_W-1:0]         i2c_data_r_i
);

   localparam int IDX_W = (NUM_REQ > 2) ? 2 : 1;

   arb_state_e          state_q,    state_d;
   logic [IDX_W-1:0]    grant_q,    grant_d;
   logic [IDX_W-1:0]    rr_ptr_q,   rr_ptr_d;
   logic [NUM_REQ-1:0]  accept_q,   accept_d;
   logic [NUM_REQ-1:0]  done_q,     done_d;
   logic                ack_q,      ack_d;
   logic [DATA_W-1:0]   data_r_q,   data_r_d;
   logic                exec_q,     exec_d;
   logic                rh_wl_q,    rh_wl_d;
   logic                bit_ctrl_q, bit_ctrl_d;
   logic [ADDR_W-1:0]   addr_q,     addr_d;
   logic [DATA_W-1:0]   data_w_q,   data_w_d;
`ifdef I2C_ARB_TIMEOUT_EN
   logic [CNT_W-1:0]    cnt_q,      cnt_d;
   logic                timeout_q,  timeout_d;
`endif

   logic [NUM_REQ-1:0]  pick_grant;
   logic [IDX_W-1:0]    pick_idx;
   logic                pick_any;
   logic [IDX_W-1:0]    next_ptr;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_pick (
      .req_i   (req_valid_i),
      .ptr_i   (rr_ptr_q),
      .grant_o (pick_grant),
      .idx_o   (pick_idx),
      .any_o   (pick_any)
   );

   // Priority moves to the requester after the one just served so that a
   // requester holding req_valid high cannot win twice in a row.
   assign next_ptr = IDX_W'((int'(grant_q) + 1) % NUM_REQ);

   // Next-state and output logic. Pulses (accept, done, exec, timeout)
   // default low every cycle; latched fields default to holding.
   // exec is registered from ISSUE so it appears two cycles after valid.
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      rr_ptr_d   = rr_ptr_q;
      accept_d   = '0;
      done_d     = '0;
      ack_d      = ack_q;
      data_r_d   = data_r_q;
      exec_d     = 1'b0;
      rh_wl_d    = rh_wl_q;
      bit_ctrl_d = bit_ctrl_q;
      addr_d     = addr_q;
      data_w_d   = data_w_q;
`ifdef I2C_ARB_TIMEOUT_EN
      cnt_d      = cnt_q;
      timeout_d  = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (pick_any) begin
               accept_d   = pick_grant;
               grant_d    = pick_idx;
               rh_wl_d    = req_rh_wl_i[pick_idx];
               bit_ctrl_d = req_bit_ctrl_i[pick_idx];
               addr_d     = req_addr_i[int'(pick_idx)*ADDR_W +: ADDR_W];
               data_w_d   = req_data_w_i[int'(pick_idx)*DATA_W +: DATA_W];
               state_d    = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            exec_d  = 1'b1;
`ifdef I2C_ARB_TIMEOUT_EN
            cnt_d   = '0;
`endif
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (i2c_done_i) begin
               done_d[grant_q] = 1'b1;
               ack_d           = i2c_ack_i;
               data_r_d        = i2c_data_r_i;
               rr_ptr_d        = next_ptr;
               state_d         = ST_IDLE;
            end
`ifdef I2C_ARB_TIMEOUT_EN
            else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
               done_d[grant_q] = 1'b1;
               ack_d           = 1'b1;
               data_r_d        = '0;
               timeout_d       = 1'b1;
               rr_ptr_d        = next_ptr;
               state_d         = ST_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset; a reset during a
   // transfer simply drops it without a response.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         grant_q    <= '0;
         rr_ptr_q   <= '0;
         accept_q   <= '0;
         done_q     <= '0;
         ack_q      <= 1'b0;
         data_r_q   <= '0;
         exec_q     <= 1'b0;
         rh_wl_q    <= 1'b0;
         bit_ctrl_q <= 1'b0;
         addr_q     <= '0;
         data_w_q   <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
         cnt_q      <= '0;
         timeout_q  <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         rr_ptr_q   <= rr_ptr_d;
         accept_q   <= accept_d;
         done_q     <= done_d;
         ack_q      <= ack_d;
         data_r_q   <= data_r_d;
         exec_q     <= exec_d;
         rh_wl_q    <= rh_wl_d;
         bit_ctrl_q <= bit_ctrl_d;
         addr_q     <= addr_d;
         data_w_q   <= data_w_d;
`ifdef I2C_ARB_TIMEOUT_EN
         cnt_q      <= cnt_d;
         timeout_q  <= timeout_d;
`endif
      end
   end

   assign req_accept_o  = accept_q;
   assign rsp_done_o    = done_q;
   assign rsp_ack_o     = ack_q;
   assign rsp_data_r_o  = data_r_q;
   assign busy_o        = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
   assign i2c_exec_o    = exec_q;
   assign i2c_rh_wl_o   = rh_wl_q;
   assign bit_ctrl_o    = bit_ctrl_q;
   assign i2c_addr_o    = addr_q;
   assign i2c_data_w_o  = data_w_q;
`ifdef I2C_ARB_TIMEOUT_EN
   assign rsp_timeout_o = timeout_q;
`endif

endmodule
